// File: rtl/arb_mux_nx_if.sv
// Handshake bus for arb_mux_nx: N packed input channels in, one registered output channel out.
// The master side drives the channels and consumes Y. The slave side is the arbiter itself.
interface arb_mux_nx_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] A;
    logic [N-1:0]       AV;
    logic [N-1:0]       AR;
    logic [SW-1:0]      S;
    logic               MODE;
    logic [WIDTH-1:0]   Y;
    logic               YV;
    logic               YR;
    logic [SW-1:0]      GNT;

    modport master (
        output A, AV, S, MODE, YR,
        input  AR, Y, YV, GNT
    );

    modport slave (
        input  A, AV, S, MODE, YR,
        output AR, Y, YV, GNT
    );
endinterface

// File: rtl/arb_mux_nx.sv
// N-channel registered selector with valid/ready handshakes. The channel is chosen
// either by a fixed select (MODE=0) or by round-robin arbitration (MODE=1).
module arb_mux_nx #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic        CLK,
    input  logic        CLRN,
    arb_mux_nx_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] y_q, y_d;
    logic             yv_q, yv_d;
    logic [SW-1:0]    gnt_q, gnt_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic             ld;
    logic             cand_vld;
    logic [SW-1:0]    cand_idx;
    logic [WIDTH-1:0] cand_dat;
    logic [N-1:0]     ar;

    // The output register can take a word when it is empty or is being drained this cycle
    assign ld = ~yv_q | bus.YR;

    always_comb begin
        int j;
        cand_vld = 1'b0;
        cand_idx = '0;
        j        = 0;
        if (!bus.MODE) begin
            // A select value of N or more matches no channel, so nothing is chosen
            for (int i = 0; i < N; i++) begin
                if (bus.S == SW'(i) && bus.AV[i]) begin
                    cand_vld = 1'b1;
                    cand_idx = SW'(i);
                end
            end
        end else begin
            // Search starts one past the last grant, so the last winner is checked last
            for (int k = 1; k <= N; k++) begin
                j = (int'(ptr_q) + k) % N;
                if (!cand_vld && bus.AV[j]) begin
                    cand_vld = 1'b1;
                    cand_idx = SW'(j);
                end
            end
        end
    end

    always_comb begin
        cand_dat = '0;
        ar       = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_idx == SW'(i)) begin
                cand_dat = bus.A[i*WIDTH +: WIDTH];
                ar[i]    = CLRN & ld & cand_vld;
            end
        end
    end

    always_comb begin
        y_d   = y_q;
        yv_d  = yv_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        if (ld) begin
            if (cand_vld) begin
                y_d   = cand_dat;
                yv_d  = 1'b1;
                gnt_d = cand_idx;
                if (bus.MODE) ptr_d = cand_idx;
            end else begin
                yv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            y_q   <= '0;
            yv_q  <= 1'b0;
            gnt_q <= '0;
            ptr_q <= SW'(N-1);
        end else begin
            y_q   <= y_d;
            yv_q  <= yv_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign bus.AR  = ar;
    assign bus.Y   = y_q;
    assign bus.YV  = yv_q;
    assign bus.GNT = gnt_q;
endmodule
